// File: rtl/idct_mul_sched_if.sv
// rtl/idct_mul_sched_if.sv - start/done handshake and wrapper control bundle for idct_mul_sched
interface idct_mul_sched_if;
    logic       start;
    logic       apx_mode;
    logic [2:0] state_out;
    logic [8:0] count0;
    logic       racc_out;
    logic       rapx_out;
    logic       rstP_out;
    logic       busy;
    logic       p_valid;
    logic       done;

    modport master (
        output start, apx_mode,
        input  state_out, count0, racc_out, rapx_out, rstP_out, busy, p_valid, done
    );

    modport slave (
        input  start, apx_mode,
        output state_out, count0, racc_out, rapx_out, rstP_out, busy, p_valid, done
    );
endinterface

// File: rtl/idct_mul_sched.sv
// rtl/idct_mul_sched.sv - phase sequencer for the IDCT multiplier wrapper (optional MUL_SCHED_SKIP_LOW_EN)
module idct_mul_sched #(
    parameter int FILL_LEN   = 64,
    parameter int LOW_LEN    = 4,
    parameter int HIGH_LEN   = 4,
    parameter int PVALID_LAT = 3
) (
    input  logic               clk,
    input  logic               rstN,
    idct_mul_sched_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_FILL  = 3'b001,
        ST_LOW   = 3'b010,
        ST_HIGH  = 3'b011,
        ST_DRAIN = 3'b100
    } state_t;

    localparam logic [8:0] FILL_LAST  = 9'(FILL_LEN - 1);
    localparam logic [8:0] LOW_LAST   = 9'(LOW_LEN - 1);
    localparam logic [8:0] HIGH_LAST  = 9'(HIGH_LEN - 1);
    localparam logic [8:0] DRAIN_LAST = 9'(PVALID_LAT - 1);

    state_t                  state_q, state_n;
    logic [8:0]              count_q, count_n;
    logic                    apx_q, apx_n;
    logic                    racc_q, rapx_q, rstp_q, busy_q, done_q;
    logic [PVALID_LAT-1:0]   pv_sr;
    logic                    product_phase;

    // Next-state and counter: each phase counts up to its last cycle, then hands over at count 0
    always_comb begin
        state_n = state_q;
        count_n = count_q;
        apx_n   = apx_q;
        case (state_q)
            ST_IDLE: begin
                count_n = 9'd0;
                if (bus.start) begin
                    state_n = ST_FILL;
                    apx_n   = bus.apx_mode;
                end
            end
            ST_FILL: begin
                if (count_q == FILL_LAST) begin
                    count_n = 9'd0;
`ifdef MUL_SCHED_SKIP_LOW_EN
                    state_n = apx_q ? ST_HIGH : ST_LOW;
`else
                    state_n = ST_LOW;
`endif
                end else begin
                    count_n = count_q + 9'd1;
                end
            end
            ST_LOW: begin
                if (count_q == LOW_LAST) begin
                    count_n = 9'd0;
                    state_n = ST_HIGH;
                end else begin
                    count_n = count_q + 9'd1;
                end
            end
            ST_HIGH: begin
                if (count_q == HIGH_LAST) begin
                    count_n = 9'd0;
                    state_n = ST_DRAIN;
                end else begin
                    count_n = count_q + 9'd1;
                end
            end
            ST_DRAIN: begin
                if (count_q == DRAIN_LAST) begin
                    count_n = 9'd0;
                    state_n = ST_IDLE;
                end else begin
                    count_n = count_q + 9'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                count_n = 9'd0;
            end
        endcase
    end

    // State, counter and registered controls; outputs are derived from the next state so they align with it
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            count_q <= 9'd0;
            apx_q   <= 1'b0;
            racc_q  <= 1'b1;
            rapx_q  <= 1'b0;
            rstp_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            apx_q   <= apx_n;
            // wrapper operands and product are cleared on the first FILL cycle only
            racc_q  <= (state_q == ST_IDLE) && (state_n == ST_FILL);
            rstp_q  <= (state_q == ST_IDLE) && (state_n == ST_FILL);
            rapx_q  <= (state_n != ST_IDLE) && apx_n;
            busy_q  <= (state_n != ST_IDLE);
            done_q  <= (state_n == ST_DRAIN) && (count_n == DRAIN_LAST);
        end
    end

    assign product_phase = (state_q == ST_LOW) || (state_q == ST_HIGH);

    // Track the wrapper's pipeline: a product appears PVALID_LAT cycles after a LOW/HIGH phase code
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pv_sr <= '0;
        end else begin
            pv_sr[0] <= product_phase;
            for (int i = 1; i < PVALID_LAT; i++) begin
                pv_sr[i] <= pv_sr[i-1];
            end
        end
    end

    assign bus.state_out = state_q;
    assign bus.count0    = count_q;
    assign bus.racc_out  = racc_q;
    assign bus.rapx_out  = rapx_q;
    assign bus.rstP_out  = rstp_q;
    assign bus.busy      = busy_q;
    assign bus.p_valid   = pv_sr[PVALID_LAT-1];
    assign bus.done      = done_q;

endmodule

// File: tb/tb_idct_mul_sched.sv
// tb/tb_idct_mul_sched.sv - directed self-checking bench for idct_mul_sched
module tb_idct_mul_sched;

    logic clk;
    logic rstN;
    int   n_checks;
    int   n_fail;

    idct_mul_sched_if bus();

    idct_mul_sched dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " state"}, 32'(bus.state_out), 0);
        chk({tag, " count0"}, 32'(bus.count0), 0);
        chk({tag, " racc"}, 32'(bus.racc_out), 1);
        chk({tag, " rapx"}, 32'(bus.rapx_out), 0);
        chk({tag, " rstP"}, 32'(bus.rstP_out), 1);
        chk({tag, " busy"}, 32'(bus.busy), 0);
        chk({tag, " p_valid"}, 32'(bus.p_valid), 0);
        chk({tag, " done"}, 32'(bus.done), 0);
    endtask

    // One run started from an idle cycle; checks every cycle against the hand-derived timeline.
    // b2b asserts start only in the done cycle, which must be ignored.
    task automatic run_check(input logic apx, input bit b2b, input string name);
        int n_low, l_end, h_end, d_end;
        int exp_state, exp_cnt;
        n_low = 4;
`ifdef MUL_SCHED_SKIP_LOW_EN
        if (apx) n_low = 0;
`endif
        l_end = 64 + n_low;
        h_end = l_end + 4;
        d_end = h_end + 3;
        bus.start    = 1'b1;
        bus.apx_mode = apx;
        for (int c = 1; c <= d_end + 3; c++) begin
            @(posedge clk);
            #1;
            if (c <= 64)         begin exp_state = 1; exp_cnt = c - 1;         end
            else if (c <= l_end) begin exp_state = 2; exp_cnt = c - 65;        end
            else if (c <= h_end) begin exp_state = 3; exp_cnt = c - l_end - 1; end
            else if (c <= d_end) begin exp_state = 4; exp_cnt = c - h_end - 1; end
            else                 begin exp_state = 0; exp_cnt = 0;             end
            chk($sformatf("%s c%0d state", name, c), 32'(bus.state_out), 32'(exp_state));
            chk($sformatf("%s c%0d count0", name, c), 32'(bus.count0), 32'(exp_cnt));
            chk($sformatf("%s c%0d busy", name, c), 32'(bus.busy), 32'(c <= d_end));
            chk($sformatf("%s c%0d p_valid", name, c), 32'(bus.p_valid), 32'(c >= 68 && c <= d_end));
            chk($sformatf("%s c%0d done", name, c), 32'(bus.done), 32'(c == d_end));
            chk($sformatf("%s c%0d racc", name, c), 32'(bus.racc_out), 32'(c == 1));
            chk($sformatf("%s c%0d rstP", name, c), 32'(bus.rstP_out), 32'(c == 1));
            chk($sformatf("%s c%0d rapx", name, c), 32'(bus.rapx_out), 32'(apx && c <= d_end));
            // inputs for cycle c
            bus.start = 1'b0;
            if (c == 10) bus.apx_mode = ~apx;
            if (b2b && c == d_end) bus.start = 1'b1;
        end
        bus.start    = 1'b0;
        bus.apx_mode = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rstN         = 1'b0;
        bus.start    = 1'b0;
        bus.apx_mode = 1'b0;

        // reset values, then idle with start low
        #12;
        chk_reset_values("reset");
        rstN = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle c%0d state", c), 32'(bus.state_out), 0);
            chk($sformatf("idle c%0d racc", c), 32'(bus.racc_out), 0);
            chk($sformatf("idle c%0d rstP", c), 32'(bus.rstP_out), 0);
            chk($sformatf("idle c%0d busy", c), 32'(bus.busy), 0);
            chk($sformatf("idle c%0d p_valid", c), 32'(bus.p_valid), 0);
            chk($sformatf("idle c%0d done", c), 32'(bus.done), 0);
        end

        // default run; start in done cycle ignored (checked through cycles 76..78)
        run_check(1'b0, 1'b1, "dflt");
        // approximate run
        run_check(1'b1, 1'b0, "apx");

        // start held high: runs begin on edges 0, 76, 152; apx toggles mid-run are ignored
        bus.start    = 1'b1;
        bus.apx_mode = 1'b0;
        for (int c = 1; c <= 153; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 || c == 77 || c == 153)
                chk($sformatf("held c%0d fill", c), 32'(bus.state_out), 1);
            if (c == 76 || c == 152)
                chk($sformatf("held c%0d idle", c), 32'(bus.state_out), 0);
            if (c == 75 || c == 151)
                chk($sformatf("held c%0d done", c), 32'(bus.done), 1);
            if (c == 20 || c == 50)
                chk($sformatf("held c%0d rapx", c), 32'(bus.rapx_out), 0);
            bus.apx_mode = (c >= 10 && c <= 70);
        end
        bus.start    = 1'b0;
        bus.apx_mode = 1'b0;
        for (int c = 0; c < 80; c++) @(posedge clk);
        #1;
        chk("held end idle", 32'(bus.state_out), 0);

        // reset during HIGH cycle 70
        bus.start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        chk("mid c70 state", 32'(bus.state_out), 3);
        chk("mid c70 p_valid", 32'(bus.p_valid), 1);
        #2;
        rstN = 1'b0;
        #1;
        chk_reset_values("async");
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post c%0d p_valid", c), 32'(bus.p_valid), 0);
            chk($sformatf("post c%0d done", c), 32'(bus.done), 0);
            chk($sformatf("post c%0d state", c), 32'(bus.state_out), 0);
        end
        run_check(1'b0, 1'b0, "clean");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/idct_mul_sched.md
# idct_mul_sched

Sequencer for the flexible-precision IDCT multiplier wrapper. It generates the 3-bit phase code, the 9-bit fill counter and the racc/rapx/rstP controls that the wrapper consumes. Each run uses a start/done handshake with the IDCT datapath control. It marks the cycles on which the wrapper's registered product P is valid, so the accumulator downstream can capture it without tracking the wrapper's internal pipeline.

## Interface
Parameters:
- FILL_LEN, 64: cycles in FILL phase; count0 terminal value is FILL_LEN-1 (legal range 1..512).
- LOW_LEN, 4: cycles in LOW (lower-chunk) phase; 1..512.
- HIGH_LEN, 4: cycles in HIGH phase; 1..512.
- PVALID_LAT, 3: cycles from phase code issue to valid P (wrapper state register, operand register, product register); also DRAIN length; 1..7.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstN  in  1  asynchronous, active-low reset.
- start  in  1  request one multiply run; honoured only in IDLE.
- apx_mode  in  1  approximate-mode request; sampled on the start-acceptance edge.
- state_out  out  3  phase code to wrapper: 000 IDLE, 001 FILL, 010 LOW, 011 HIGH, 100 DRAIN.
- count0  out  9  phase cycle counter to wrapper.
- racc_out  out  1  wrapper accurate-bit/state reset, active high.
- rapx_out  out  1  wrapper approximate-bit control.
- rstP_out  out  1  wrapper product-register clear, active high.
- busy  out  1  high from FILL through DRAIN inclusive.
- p_valid  out  1  wrapper P holds a product this cycle.
- done  out  1  one-cycle pulse in the final DRAIN cycle.

## Operation
- All outputs are registered.
- Reset values: state_out 000, count0 0, racc_out 1, rapx_out 0, rstP_out 1, busy 0, p_valid 0, done 0.
- First edge after rstN deasserts: racc_out and rstP_out go to 0.
- IDLE:
  - start=1 → FILL; count0 0.
  - apx_mode is latched; rapx_out follows the latched value for the whole run.
  - start=0 → remain in IDLE.
- FILL:
  - count0 increments by 1 per cycle.
  - On count0==FILL_LEN-1 → LOW, with count0 reset to 0.
  - racc_out and rstP_out are 1 on the first FILL cycle only, clearing wrapper operands and product.
- LOW: count0 increments; on count0==LOW_LEN-1 → HIGH, count0 0.
- HIGH: count0 increments; on count0==HIGH_LEN-1 → DRAIN, count0 0.
- DRAIN:
  - count0 increments; on count0==PVALID_LAT-1 → IDLE, count0 0.
  - done=1 during that final DRAIN cycle.
- p_valid: a PVALID_LAT-deep shift register fed with (state_out==LOW or HIGH). It is cleared on reset only, not on start.
- count0 never exceeds its phase limit. No wrap occurs at 511 because phase limits are ≤512.
- start while busy: ignored, not queued. apx_mode changes mid-run: ignored.
- start asserted in the done cycle: ignored. A new run needs start in a later IDLE cycle.
- Reset mid-run: the run is abandoned immediately (asynchronous). All outputs take reset values, the p_valid pipeline is flushed, and no done is issued.
- Unused state codes 101–111 (only reachable by upset): next state IDLE, count0 0.

## Timing
- Start accepted on edge 0 → state_out=001, busy=1 from cycle 1.
- With defaults:
  - FILL: cycles 1–64.
  - LOW: cycles 65–68.
  - HIGH: cycles 69–72.
  - DRAIN: cycles 73–75.
  - IDLE: from cycle 76.
- p_valid is high on cycles 68–75 (8 pulses). done is high on cycle 75, and busy drops at cycle 76.
- Run length is FILL_LEN+LOW_LEN+HIGH_LEN+PVALID_LAT cycles. Minimum start-to-start spacing is run length + 1.

## Configuration
- MUL_SCHED_SKIP_LOW_EN defined:
  - When the latched apx_mode=1, FILL transitions directly to HIGH and LOW is skipped.
  - With defaults, the run is 71 cycles and produces 4 p_valid pulses.
  - When apx_mode=0, the run is unchanged.
- MUL_SCHED_SKIP_LOW_EN undefined: LOW always executes regardless of apx_mode; apx_mode affects only rapx_out.

## Test plan
- Reset, then hold start=0 for 20 cycles → state_out=000, racc_out=0 and rstP_out=0 after the first edge, no p_valid or done.
- Default run: start=1 for one cycle with apx_mode=0 → phase boundaries at cycles 1/65/69/73, count0 reaches 63 on cycle 64, p_valid on cycles 68–75, done on cycle 75, rapx_out=0 throughout.
- Approximate run: start with apx_mode=1 under MUL_SCHED_SKIP_LOW_EN → HIGH on cycles 65–68, DRAIN on cycles 69–71, done on cycle 71, rapx_out=1 on cycles 1–71. Without the macro → same timing as the default run with rapx_out=1.
- start held high continuously → runs begin on edges 0, 76 and 152. Toggling apx_mode inside a run does not change rapx_out.
- rstN pulled low in HIGH cycle 70 → all outputs reset asynchronously. No p_valid or done follows. After release, start runs a clean default sequence.
- Back-to-back: start asserted in the done cycle (cycle 75) is ignored. start asserted in cycle 76 is accepted, with FILL from cycle 77.
